xs3_to_bcd_deserializer: RTL and testbench
==========================================

// Module: xs3_to_bcd_deserializer
// PURPOSE
//   Receive-side partner of the BCD->Excess-3 encoder path.
//   Accepts one Excess-3 digit per valid/ready handshake, most-significant digit first.
//   Converts each digit to BCD, checks it for validity, and packs a frame of up to DIGITS digits into one right-aligned BCD word.
//   Presents the word on a valid/ready output port to downstream display/arithmetic logic.
// PARAMETERS
//   DIGITS  4  max BCD digits per frame (>=2); out_bcd width = 4*DIGITS
// PORTS
//   clk           input   1           rising-edge clock
//   reset         input   1           synchronous, active-high reset
//   in_xs3        input   4           Excess-3 digit
//   in_valid      input   1           in_xs3/in_last valid
//   in_last       input   1           digit is final of frame
//   in_ready      output  1           block accepts a digit this cycle
//   out_bcd       output  4*DIGITS    packed BCD word, digit 0 = bits[3:0] = least significant digit
//   out_count     output  clog2(DIGITS+1)  digits in frame (1..DIGITS)
//   out_err       output  1           >=1 invalid digit in frame
//   out_err_mask  output  DIGITS      bit i set = digit i was invalid
//   out_valid     output  1           output word valid
//   out_ready     input   1           downstream accepts word
// BEHAVIOUR
//   Synchronous, active-high reset; all outputs registered.
//     Reset values: state=COLLECT, in_ready=1, out_valid=0, out_bcd=0, out_count=0, out_err=0, out_err_mask=0.
//   Handshakes: input beat = in_valid & in_ready; output beat = out_valid & out_ready.
//   FSM, two states:
//     COLLECT: in_ready=1, out_valid=0.
//       On each input beat: shift word left 4, insert converted digit at [3:0]; shift err mask left 1, insert invalid bit at [0]; count+1.
//       End of frame when the beat has in_last=1, or the beat is the DIGITS-th digit (in_last ignored then) -> HOLD.
//     HOLD: in_ready=0, out_valid=1; outputs stable until output beat.
//       On output beat -> COLLECT; word, mask and count cleared in the same edge.
//   Conversion: bcd = in_xs3 - 4'd3 (mod 16).
//     Valid codes: 4'h3..4'hC. Any other code: digit stored as 4'h0, mask bit set, out_err=1.
//   Short frames: leading digits read 0 (word cleared at frame start) -> right-aligned result.
//   Latency: out_valid rises the cycle after the final input beat; in_ready is low from then until the cycle after the output beat (one bubble per frame).
//   in_valid=0 in COLLECT: no state change; a partial frame is held indefinitely.
//   out_ready=0 in HOLD: back-pressure; in_xs3 ignored, nothing dropped or altered.
//   out_err = |out_err_mask at all times.
//   Reset mid-frame or during HOLD discards the partial/pending word; the next accepted digit starts a new frame.
// TESTING
//   1 Digits 4'h4,5'h8,4'h6,4'h9 (last on 4th), out_ready=1
//       -> out_bcd=16'h1536, out_count=4, out_err=0, out_valid one cycle after 4th beat.
//   2 Digits 4'hC,4'h3 with in_last on 2nd
//       -> out_bcd=16'h0090, out_count=2, mask=0.
//   3 Digits 4'h3,4'h0,4'hF,4'h7
//       -> out_bcd=16'h0004, out_err=1, out_err_mask=4'b0110.
//   4 Hold out_ready=0 for 10 cycles in HOLD while in_valid=1
//       -> in_ready=0 throughout, outputs stable, no digit consumed; release -> next frame correct.
//   5 5 digits without in_last, DIGITS=4
//       -> frame closes after 4th beat; 5th digit starts the next frame with count=1.
//   6 reset after 2 beats, then frame 4'h5,4'h6 (last)
//       -> out_bcd=16'h0023, no leftover digits.

Source files
------------

// File: rtl/xs3_to_bcd_deserializer_if.sv
// Digit-in / word-out handshake bundle for the Excess-3 to BCD deserializer.
// master = upstream digit source plus downstream word sink; slave = the deserializer.
interface xs3_to_bcd_deserializer_if #(
    parameter int DIGITS = 4
);
    logic [3:0]                     in_xs3;
    logic                           in_valid;
    logic                           in_last;
    logic                           in_ready;
    logic [4*DIGITS-1:0]            out_bcd;
    logic [$clog2(DIGITS+1)-1:0]    out_count;
    logic                           out_err;
    logic [DIGITS-1:0]              out_err_mask;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output in_xs3, in_valid, in_last, out_ready,
        input  in_ready, out_bcd, out_count, out_err, out_err_mask, out_valid
    );

    modport slave (
        input  in_xs3, in_valid, in_last, out_ready,
        output in_ready, out_bcd, out_count, out_err, out_err_mask, out_valid
    );
endinterface

// File: rtl/xs3_to_bcd_deserializer.sv
// Collects Excess-3 digits (MSD first) into a right-aligned packed BCD word and
// presents it on a valid/ready port, flagging any out-of-range digit codes.
module xs3_to_bcd_deserializer #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    xs3_to_bcd_deserializer_if.slave  bus
);
    localparam int                WORD_W   = 4 * DIGITS;
    localparam int                CNT_W    = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DIGITS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic logic xs3_bad(input logic [3:0] code);
        return (code < 4'h3) || (code > 4'hC);
    endfunction

    // Invalid codes are stored as zero so the word stays legal BCD.
    function automatic logic [3:0] xs3_to_bcd(input logic [3:0] code);
        return xs3_bad(code) ? 4'h0 : (code - 4'd3);
    endfunction

    state_t             r_state;
    logic [WORD_W-1:0]  r_word;
    logic [DIGITS-1:0]  r_mask;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [3:0]         w_digit;
    logic               w_bad;
    logic               w_in_beat;
    logic               w_out_beat;
    logic               w_frame_end;

    assign w_digit     = xs3_to_bcd(bus.in_xs3);
    assign w_bad       = xs3_bad(bus.in_xs3);
    assign w_in_beat   = bus.in_valid & r_in_ready;
    assign w_out_beat  = r_out_valid & bus.out_ready;
    assign w_frame_end = bus.in_last | (r_count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_word      <= '0;
            r_mask      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_in_beat) begin
                        r_word  <= {r_word[WORD_W-5:0], w_digit};
                        r_mask  <= {r_mask[DIGITS-2:0], w_bad};
                        r_count <= r_count + 1'b1;
                        r_err   <= r_err | w_bad;
                        if (w_frame_end) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Clearing here makes the next frame start from zero, giving right alignment.
                    if (w_out_beat) begin
                        r_state     <= COLLECT;
                        r_word      <= '0;
                        r_mask      <= '0;
                        r_count     <= '0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= COLLECT;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_bcd      = r_word;
    assign bus.out_count    = r_count;
    assign bus.out_err      = r_err;
    assign bus.out_err_mask = r_mask;
endmodule

// File: tb/tb_xs3_to_bcd_deserializer.sv
// Bench for xs3_to_bcd_deserializer: directed frames with literal expectations plus
// randomized traffic checked every cycle against a frame-level behavioural model.
module tb_xs3_to_bcd_deserializer;
    localparam int DIGITS = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    xs3_to_bcd_deserializer_if #(.DIGITS(DIGITS)) bus ();

    xs3_to_bcd_deserializer #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digits of the open frame, and the pending expected word.
    int          cur[$];
    bit          pend;
    bit          just_rst;
    logic [63:0] exp_word;
    logic [63:0] exp_mask;
    int          exp_count;

    task automatic build_expect();
        int n;
        n         = cur.size();
        exp_word  = 0;
        exp_mask  = 0;
        exp_count = n;
        for (int k = 0; k < n; k++) begin
            int pos;
            pos = n - 1 - k;
            if (cur[k] >= 3 && cur[k] <= 12) exp_word += 64'(cur[k] - 3) * (64'd1 << (4 * pos));
            else                             exp_mask |= (64'd1 << pos);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cur.delete();
            pend     = 1'b0;
            just_rst = 1'b1;
        end else begin
            chk("in_ready", bus.in_ready, !pend);
            chk("out_valid", bus.out_valid, pend);
            if (just_rst) begin
                chk("rst_bcd", bus.out_bcd, 0);
                chk("rst_count", bus.out_count, 0);
                chk("rst_mask", bus.out_err_mask, 0);
                chk("rst_err", bus.out_err, 0);
                just_rst = 1'b0;
            end
            if (pend) begin
                chk("model_bcd", bus.out_bcd, exp_word);
                chk("model_count", bus.out_count, exp_count);
                chk("model_mask", bus.out_err_mask, exp_mask);
                chk("model_err", bus.out_err, exp_mask != 0);
                if (bus.out_ready) pend = 1'b0;
            end else if (bus.in_valid) begin
                cur.push_back(int'(bus.in_xs3));
                if (bus.in_last || cur.size() == DIGITS) begin
                    build_expect();
                    pend = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    // Offer one digit and hold it until the DUT accepts it.
    task automatic put(input logic [3:0] code, input logic last);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_xs3   = code;
        bus.in_last  = last;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL put_timeout actual=no_accept expected=accept t=%0t", $time);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_xs3      = 4'h0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // MSD-first frame of four valid digits.
        put(4'h4, 1'b0); put(4'h8, 1'b0); put(4'h6, 1'b0); put(4'h9, 1'b1);
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_bcd", bus.out_bcd, 16'h1536);
        chk("t1_count", bus.out_count, 4);
        chk("t1_err", bus.out_err, 0);

        // Short frame is right-aligned.
        put(4'hC, 1'b0); put(4'h3, 1'b1);
        @(negedge clk);
        chk("t2_bcd", bus.out_bcd, 16'h0090);
        chk("t2_count", bus.out_count, 2);
        chk("t2_mask", bus.out_err_mask, 0);

        // Invalid codes in positions 2 and 1.
        put(4'h3, 1'b0); put(4'h0, 1'b0); put(4'hF, 1'b0); put(4'h7, 1'b0);
        @(negedge clk);
        chk("t3_bcd", bus.out_bcd, 16'h0004);
        chk("t3_err", bus.out_err, 1);
        chk("t3_mask", bus.out_err_mask, 4'b0110);

        // Back-pressure in HOLD with a digit offered the whole time.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        put(4'h4, 1'b0); put(4'h5, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_xs3   = 4'h7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_in_ready", bus.in_ready, 0);
            chk("t4_valid", bus.out_valid, 1);
            chk("t4_bcd", bus.out_bcd, 16'h0012);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        put(4'h6, 1'b0); put(4'h7, 1'b1);
        @(negedge clk);
        chk("t4_next_bcd", bus.out_bcd, 16'h0034);
        chk("t4_next_count", bus.out_count, 2);

        // Fifth digit without in_last begins a fresh frame.
        put(4'h4, 1'b0); put(4'h5, 1'b0); put(4'h6, 1'b0); put(4'h7, 1'b0);
        @(negedge clk);
        chk("t5_bcd", bus.out_bcd, 16'h1234);
        chk("t5_count", bus.out_count, 4);
        put(4'h8, 1'b1);
        @(negedge clk);
        chk("t5_next_bcd", bus.out_bcd, 16'h0005);
        chk("t5_next_count", bus.out_count, 1);

        // Reset mid-frame discards the partial word.
        put(4'h4, 1'b0); put(4'h5, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        put(4'h5, 1'b0); put(4'h6, 1'b1);
        @(negedge clk);
        chk("t6_bcd", bus.out_bcd, 16'h0023);
        chk("t6_count", bus.out_count, 2);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset         = ($urandom_range(0, 249) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_xs3    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(3, 12));
            bus.in_last   = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
